// File: rtl/button_debounce.sv
// button_debounce: conditions active-low pull-up button pins into debounced active-high
// levels with one-cycle press/release pulses and a one-shot long-press pulse per channel.
module button_debounce #(
   parameter int NUM_BUTTONS     = 3,
   parameter int CLOCK_HZ        = 12_000_000,
   parameter int DEBOUNCE_US     = 10_000,
   parameter int DEBOUNCE_CYCLES = (CLOCK_HZ / 1_000_000) * DEBOUNCE_US,
   parameter int LONG_CYCLES     = CLOCK_HZ
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_BUTTONS-1:0] button_raw_i,
   output logic [NUM_BUTTONS-1:0] button_o,
   output logic [NUM_BUTTONS-1:0] pressed_o,
   output logic [NUM_BUTTONS-1:0] released_o,
   output logic [NUM_BUTTONS-1:0] long_o
);

   localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LCW = $clog2(LONG_CYCLES + 1);
   localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LCW-1:0] LONG_MAX = LCW'(LONG_CYCLES);
   localparam logic [LCW-1:0] LONG_PRE = LCW'(LONG_CYCLES - 1);

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
      logic           sync1;
      logic           sync2;
      logic           s;
      logic           level;
      logic           pressed_q;
      logic           released_q;
      logic           long_q;
      logic [DCW-1:0] db_cnt;
      logic [LCW-1:0] hold_cnt;

      // Flops reset to the released (high) pin level so reset release sees no edge.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
         end else begin
            sync1 <= button_raw_i[g];
            sync2 <= sync1;
         end
      end

      assign s = ~sync2;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            level      <= 1'b0;
            db_cnt     <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
         end else begin
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            if (s == level) begin
               db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
               level      <= s;
               db_cnt     <= '0;
               pressed_q  <= s;
               released_q <= ~s;
            end else begin
               db_cnt <= db_cnt + DCW'(1);
            end
         end
      end

      // Saturating hold counter: the pulse fires only on the step into LONG_MAX.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
         end else if (!level) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
         end else begin
            long_q <= 1'b0;
            if (hold_cnt != LONG_MAX) begin
               hold_cnt <= hold_cnt + LCW'(1);
               long_q   <= (hold_cnt == LONG_PRE);
            end
         end
      end

      assign button_o[g]   = level;
      assign pressed_o[g]  = pressed_q;
      assign released_o[g] = released_q;
      assign long_o[g]     = long_q;
   end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: a history-window reference model predicts every
// cycle's outputs into a scoreboard queue; scenario tasks pop and compare plus direct checks.
module tb_button_debounce;

   localparam int N = 3;
   localparam int D = 4;
   localparam int L = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] button_raw_i = '0;
   logic [N-1:0] button_o;
   logic [N-1:0] pressed_o;
   logic [N-1:0] released_o;
   logic [N-1:0] long_o;

   int checks = 0;
   int passes = 0;

   button_debounce #(
      .NUM_BUTTONS(N),
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES(L)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .button_raw_i(button_raw_i),
      .button_o(button_o),
      .pressed_o(pressed_o),
      .released_o(released_o),
      .long_o(long_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           cyc;
      logic [N-1:0] b;
      logic [N-1:0] p;
      logic [N-1:0] r;
      logic [N-1:0] l;
   } exp_t;

   exp_t         exp_q[$];
   int           cyc = 0;
   logic [D-1:0] hist [N];
   logic [N-1:0] deb_m;
   int           pend [N];
   exp_t         e;

   // Reference: a level flips once the last D raw samples all oppose the debounced level;
   // that sample window reaches the output two edges after its newest sample.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_q.delete();
         deb_m = '0;
         for (int c = 0; c < N; c++) begin
            hist[c] = '1;
            pend[c] = -1;
         end
      end else begin
         cyc   = cyc + 1;
         e.cyc = cyc + 2;
         e.p   = '0;
         e.r   = '0;
         e.l   = '0;
         for (int c = 0; c < N; c++) begin
            hist[c] = {hist[c][D-2:0], button_raw_i[c]};
            if (deb_m[c] && pend[c] >= 0 && e.cyc == pend[c] + L) begin
               e.l[c]  = 1'b1;
               pend[c] = -1;
            end
            if (hist[c] == {D{deb_m[c]}}) begin
               if (!deb_m[c]) begin
                  e.p[c]  = 1'b1;
                  pend[c] = e.cyc;
               end else begin
                  e.r[c]  = 1'b1;
                  pend[c] = -1;
               end
               deb_m[c] = ~deb_m[c];
            end
         end
         e.b = deb_m;
         exp_q.push_back(e);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic get_exp(output logic [N-1:0] eb, output logic [N-1:0] ep,
                          output logic [N-1:0] er, output logic [N-1:0] el);
      exp_t x;
      eb = '0; ep = '0; er = '0; el = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         x  = exp_q.pop_front();
         eb = x.b; ep = x.p; er = x.r; el = x.l;
      end
   endtask

   task automatic test_reset();
      logic [N-1:0] eb, ep, er, el;
      int lat = 0;
      int npulse = 0;
      reset_n      = 1'b0;
      button_raw_i = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({button_o, pressed_o, released_o, long_o} !== '0)
            $display("FAIL reset_outputs: got %b required 0", {button_o, pressed_o, released_o, long_o});
         else passes++;
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         if (i == 20) button_raw_i = '1;
         tick();
         get_exp(eb, ep, er, el);
         checks++;
         if ({button_o, pressed_o, released_o, long_o} !== {eb, ep, er, el})
            $display("FAIL sb_reset cyc %0d: got %b required %b", cyc,
                     {button_o, pressed_o, released_o, long_o}, {eb, ep, er, el});
         else passes++;
         if (pressed_o == 3'b111) begin
            npulse++;
            if (lat == 0) lat = i;
         end
         if (i == 6) begin
            checks++;
            if (button_o !== 3'b111) $display("FAIL reset_level: got %b required 111", button_o);
            else passes++;
         end
      end
      checks++;
      if (lat !== 6) $display("FAIL reset_press_latency: got %0d required 6", lat);
      else passes++;
      checks++;
      if (npulse !== 1) $display("FAIL reset_press_count: got %0d required 1", npulse);
      else passes++;
   endtask

   task automatic test_press();
      logic [N-1:0] eb, ep, er, el;
      int lat = 0;
      int npulse = 0;
      logic quiet_bad = 1'b0;
      for (int i = 1; i <= 35; i++) begin
         if (i == 1)  button_raw_i[0] = 1'b0;
         if (i == 20) button_raw_i[0] = 1'b1;
         tick();
         get_exp(eb, ep, er, el);
         checks++;
         if ({button_o, pressed_o, released_o, long_o} !== {eb, ep, er, el})
            $display("FAIL sb_press cyc %0d: got %b required %b", cyc,
                     {button_o, pressed_o, released_o, long_o}, {eb, ep, er, el});
         else passes++;
         if (pressed_o[0]) begin
            npulse++;
            if (lat == 0) lat = i;
         end
         if (|{pressed_o[2:1], released_o[2:1], long_o[2:1], button_o[2:1]}) quiet_bad = 1'b1;
      end
      checks++;
      if (lat !== 6) $display("FAIL press_latency: got %0d required 6", lat);
      else passes++;
      checks++;
      if (npulse !== 1) $display("FAIL press_count: got %0d required 1", npulse);
      else passes++;
      checks++;
      if (quiet_bad !== 1'b0) $display("FAIL press_other_quiet: got %b required 0", quiet_bad);
      else passes++;
   endtask

   task automatic test_glitch();
      logic [N-1:0] eb, ep, er, el;
      logic seen = 1'b0;
      for (int i = 1; i <= 25; i++) begin
         button_raw_i[1] = !((i >= 1 && i <= 3) || (i >= 5 && i <= 7));
         tick();
         get_exp(eb, ep, er, el);
         checks++;
         if ({button_o, pressed_o, released_o, long_o} !== {eb, ep, er, el})
            $display("FAIL sb_glitch cyc %0d: got %b required %b", cyc,
                     {button_o, pressed_o, released_o, long_o}, {eb, ep, er, el});
         else passes++;
         if (button_o[1] | pressed_o[1] | released_o[1] | long_o[1]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) $display("FAIL glitch_rejected: got %b required 0", seen);
      else passes++;
   endtask

   task automatic test_long();
      logic [N-1:0] eb, ep, er, el;
      int press_t = 0, long_t = 0, rel_t = 0, np = 0, nl = 0;
      for (int i = 1; i <= 45; i++) begin
         button_raw_i[2] = (i > 20);
         tick();
         get_exp(eb, ep, er, el);
         checks++;
         if ({button_o, pressed_o, released_o, long_o} !== {eb, ep, er, el})
            $display("FAIL sb_long cyc %0d: got %b required %b", cyc,
                     {button_o, pressed_o, released_o, long_o}, {eb, ep, er, el});
         else passes++;
         if (pressed_o[2]) begin np++; press_t = i; end
         if (long_o[2]) begin nl++; long_t = i; end
         if (released_o[2]) rel_t = i;
      end
      checks++;
      if (np !== 1) $display("FAIL long_press_count: got %0d required 1", np);
      else passes++;
      checks++;
      if (nl !== 1) $display("FAIL long_count: got %0d required 1", nl);
      else passes++;
      checks++;
      if (long_t - press_t !== L) $display("FAIL long_delay: got %0d required %0d", long_t - press_t, L);
      else passes++;
      checks++;
      if (rel_t !== 26) $display("FAIL long_release_latency: got %0d required 26", rel_t);
      else passes++;
   endtask

   task automatic test_reset_mid_hold();
      logic [N-1:0] eb, ep, er, el;
      int lat = 0;
      int np = 0;
      for (int i = 1; i <= 12; i++) begin
         if (i == 1) button_raw_i[0] = 1'b0;
         tick();
         get_exp(eb, ep, er, el);
         checks++;
         if ({button_o, pressed_o, released_o, long_o} !== {eb, ep, er, el})
            $display("FAIL sb_midhold_pre cyc %0d: got %b required %b", cyc,
                     {button_o, pressed_o, released_o, long_o}, {eb, ep, er, el});
         else passes++;
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({button_o, pressed_o, released_o, long_o} !== '0)
         $display("FAIL midhold_async_clear: got %b required 0", {button_o, pressed_o, released_o, long_o});
      else passes++;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({button_o, pressed_o, released_o, long_o} !== '0)
            $display("FAIL midhold_in_reset: got %b required 0", {button_o, pressed_o, released_o, long_o});
         else passes++;
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         if (i == 20) button_raw_i[0] = 1'b1;
         tick();
         get_exp(eb, ep, er, el);
         checks++;
         if ({button_o, pressed_o, released_o, long_o} !== {eb, ep, er, el})
            $display("FAIL sb_midhold_post cyc %0d: got %b required %b", cyc,
                     {button_o, pressed_o, released_o, long_o}, {eb, ep, er, el});
         else passes++;
         if (pressed_o[0]) begin
            np++;
            if (lat == 0) lat = i;
         end
      end
      checks++;
      if (lat !== 6) $display("FAIL midhold_fresh_press_latency: got %0d required 6", lat);
      else passes++;
      checks++;
      if (np !== 1) $display("FAIL midhold_fresh_press_count: got %0d required 1", np);
      else passes++;
   endtask

   task automatic test_random_bounce();
      logic [N-1:0] eb, ep, er, el;
      logic [N-1:0] tgt = '1;
      int glch [N], since [N], flips [N], pulses [N];
      logic excl_bad = 1'b0;
      for (int c = 0; c < N; c++) begin
         glch[c] = 0; since[c] = 0; flips[c] = 0; pulses[c] = 0;
      end
      for (int i = 0; i < 1040; i++) begin
         for (int c = 0; c < N; c++) begin
            if (i >= 1000) begin
               glch[c] = 0;
            end else if (glch[c] > 0) begin
               glch[c]--;
            end else if (since[c] >= 16 && $urandom_range(0, 3) == 0) begin
               tgt[c]   = ~tgt[c];
               since[c] = 0;
               flips[c]++;
            end else if ((since[c] < 6 || since[c] >= 16) && $urandom_range(0, 7) == 0) begin
               glch[c] = int'($urandom_range(1, 3));
            end
            button_raw_i[c] = (glch[c] > 0) ? ~tgt[c] : tgt[c];
            since[c]++;
         end
         tick();
         get_exp(eb, ep, er, el);
         checks++;
         if ({button_o, pressed_o, released_o, long_o} !== {eb, ep, er, el})
            $display("FAIL sb_random cyc %0d: got %b required %b", cyc,
                     {button_o, pressed_o, released_o, long_o}, {eb, ep, er, el});
         else passes++;
         if (((pressed_o & released_o) | (pressed_o & long_o)) != '0) excl_bad = 1'b1;
         for (int c = 0; c < N; c++) pulses[c] += int'(pressed_o[c]) + int'(released_o[c]);
      end
      checks++;
      if (excl_bad !== 1'b0) $display("FAIL random_pulse_exclusive: got %b required 0", excl_bad);
      else passes++;
      for (int c = 0; c < N; c++) begin
         checks++;
         if (pulses[c] !== flips[c])
            $display("FAIL random_pulse_count ch%0d: got %0d required %0d", c, pulses[c], flips[c]);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_long();
      test_reset_mid_hold();
      test_random_bounce();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

endmodule
